// File: rtl/pico_bus_pkg.sv
// Shared FSM encoding, route codes and command-register bit positions for the Pico bus controller.
// No logic of its own; no latency and no backpressure.
package pico_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CAM_ARM    = 2'd1,
        ST_CAM_STREAM = 2'd2,
        ST_READ       = 2'd3
    } state_e;

    localparam logic [1:0] ROUTE_PICO = 2'b00;
    localparam logic [1:0] ROUTE_CAM  = 2'b01;
    localparam logic [1:0] ROUTE_SIMD = 2'b10;

    localparam int CMD_ROUTE_LSB  = 0;
    localparam int CMD_MODE_LSB   = 2;
    localparam int CMD_DTYPE_BIT  = 4;
    localparam int CMD_RDSRC_BIT  = 5;
    localparam int CMD_ERRCLR_BIT = 7;

    function automatic logic [1:0] cmd_route(input logic [7:0] cmd);
        return cmd[CMD_ROUTE_LSB +: 2];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes one async input through DEPTH flops and gives its level plus registered rise/fall pulses.
// Level lags DEPTH cycles, rise/fall one more; no backpressure.
module sync_edge #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
            prev_q <= sync_q[DEPTH-1];
            rise_q <= sync_q[DEPTH-1] & ~prev_q;
            fall_q <= ~sync_q[DEPTH-1] & prev_q;
        end
    end

    assign level_o = sync_q[DEPTH-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pico_bus_ctrl.sv
// Pico bus controller: decodes synchronized bus strobes into command/data writes, reads and camera framing.
// Strobes act SYNC_STAGES+1 cycles after the raw edge, outputs one cycle later; no backpressure, illegal accesses set err.
module pico_bus_ctrl
    import pico_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       WR,
    input  logic       RD,
    input  logic       a0,
    input  logic [7:0] pico_data_in,
    input  logic       cam_vsync,
    input  logic       simd_valid,
    output logic       sel_poc,
    output logic       sel_sod,
    output logic       direction,
    output logic       simd_load,
    output logic       simd_send,
    output logic [1:0] simd_mode,
    output logic       simd_dtype,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] rise;
    logic [4:0] fall;

    assign raw = {cam_vsync, a0, RD, WR, cs};

    for (genvar i = 0; i < 5; i++) begin : g_sync
        sync_edge #(.DEPTH(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst_n   (rst),
            .d_i     (raw[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    logic unused_edges;
    assign unused_edges = ^{fall, rise[0], rise[3], lvl[4]};

    logic cs_s, wr_s, rd_s, a0_s;
    logic wr_ev, rd_ev, vs_rise;
    assign cs_s    = lvl[0];
    assign wr_s    = lvl[1];
    assign rd_s    = lvl[2];
    assign a0_s    = lvl[3];
    assign wr_ev   = rise[1] & ~cs_s;
    assign rd_ev   = rise[2] & ~cs_s;
    assign vs_rise = rise[4];

    state_e     state_q;
    logic [7:0] cmd_q;
    logic       err_q, sel_poc_q, sel_sod_q, dir_q, load_q, send_q, fdone_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 8'h00;
            err_q     <= 1'b0;
            sel_poc_q <= 1'b0;
            sel_sod_q <= 1'b0;
            dir_q     <= 1'b0;
            load_q    <= 1'b0;
            send_q    <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            send_q  <= 1'b0;
            fdone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_ev) begin
                        // A colliding read is dropped; its error wins over a same-cycle clear.
                        if (rd_ev)
                            err_q <= 1'b1;
                        else if (!a0_s && pico_data_in[CMD_ERRCLR_BIT])
                            err_q <= 1'b0;
                        if (!a0_s) begin
                            cmd_q <= pico_data_in;
                            if (cmd_route(pico_data_in) == ROUTE_CAM)
                                state_q <= ST_CAM_ARM;
                        end else if (cmd_route(cmd_q) == ROUTE_SIMD) begin
                            load_q <= 1'b1;
                        end
                    end else if (rd_ev) begin
                        state_q   <= ST_READ;
                        sel_sod_q <= cmd_q[CMD_RDSRC_BIT];
                        if (cmd_q[CMD_RDSRC_BIT]) begin
                            if (simd_valid)
                                send_q <= 1'b1;
                            else
                                err_q <= 1'b1;
                        end
                    end
                end
                ST_CAM_ARM, ST_CAM_STREAM: begin
                    if (wr_ev && !a0_s && cmd_route(pico_data_in) == ROUTE_PICO) begin
                        cmd_q     <= pico_data_in;
                        state_q   <= ST_IDLE;
                        sel_poc_q <= 1'b0;
                        if (pico_data_in[CMD_ERRCLR_BIT])
                            err_q <= 1'b0;
                    end else begin
                        if (wr_ev || rd_ev)
                            err_q <= 1'b1;
                        if (vs_rise) begin
                            if (state_q == ST_CAM_ARM) begin
                                state_q   <= ST_CAM_STREAM;
                                sel_poc_q <= 1'b1;
                            end else begin
                                state_q   <= ST_IDLE;
                                sel_poc_q <= 1'b0;
                                fdone_q   <= 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (!rd_s || cs_s) begin
                        state_q   <= ST_IDLE;
                        dir_q     <= 1'b0;
                        sel_sod_q <= 1'b0;
                    end else begin
                        dir_q <= ~wr_s;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gate with the live synced WR so the bus is never driven against a host write.
    assign direction  = dir_q & ~wr_s;
    assign sel_poc    = sel_poc_q;
    assign sel_sod    = sel_sod_q;
    assign simd_load  = load_q;
    assign simd_send  = send_q;
    assign frame_done = fdone_q;
    assign err        = err_q;
    assign simd_mode  = cmd_q[CMD_MODE_LSB +: 2];
    assign simd_dtype = cmd_q[CMD_DTYPE_BIT];
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pico_bus_ctrl.sv
// Directed bench for pico_bus_ctrl: bus writes/reads, camera framing, collisions and async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same offset.
module tb_pico_bus_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst, cs, WR, RD, a0, cam_vsync, simd_valid;
    logic [7:0] pico_data_in;
    logic       sel_poc, sel_sod, direction, simd_load, simd_send;
    logic [1:0] simd_mode;
    logic       simd_dtype, busy, frame_done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int load_cnt = 0, load_cyc = 0, send_cnt = 0, fd_cnt = 0, dir_cnt = 0;
    int snap_load, snap_send, snap_fd, snap_dir, wr_cyc;

    pico_bus_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .WR           (WR),
        .RD           (RD),
        .a0           (a0),
        .pico_data_in (pico_data_in),
        .cam_vsync    (cam_vsync),
        .simd_valid   (simd_valid),
        .sel_poc      (sel_poc),
        .sel_sod      (sel_sod),
        .direction    (direction),
        .simd_load    (simd_load),
        .simd_send    (simd_send),
        .simd_mode    (simd_mode),
        .simd_dtype   (simd_dtype),
        .busy         (busy),
        .frame_done   (frame_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (simd_load) begin
            load_cnt = load_cnt + 1;
            load_cyc = cyc;
        end
        if (simd_send)  send_cnt = send_cnt + 1;
        if (frame_done) fd_cnt   = fd_cnt + 1;
        if (direction)  dir_cnt  = dir_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic a0v, input logic [7:0] d);
        a0 = a0v;
        pico_data_in = d;
        cs = 1'b0;
        WR = 1'b1;
        tick(6);
        WR = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic do_read(input logic exp_sod);
        cs = 1'b0;
        RD = 1'b1;
        tick(6);
        chk("read_dir_mid", direction, 1);
        chk("read_sod_mid", sel_sod, exp_sod);
        chk("read_busy_mid", busy, 1);
        RD = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(6);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b1; WR = 1'b0; RD = 1'b0; a0 = 1'b0;
        pico_data_in = 8'h00; cam_vsync = 1'b0; simd_valid = 1'b0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_dir", direction, 0);
        chk("rst_poc", sel_poc, 0);
        chk("rst_sod", sel_sod, 0);
        chk("rst_err", err, 0);
        chk("rst_mode", simd_mode, 0);
        chk("rst_load", simd_load, 0);
        chk("rst_fdone", frame_done, 0);
        rst = 1'b1;
        tick(4);

        // Command write 0x2E: mode 3, dtype 0, route SIMD, no strobe
        snap_load = load_cnt;
        bus_write(1'b0, 8'h2E);
        chk("cmd2e_mode", simd_mode, 2'b11);
        chk("cmd2e_dtype", simd_dtype, 0);
        chk("cmd2e_busy", busy, 0);
        chk("cmd2e_noload", load_cnt - snap_load, 0);

        // Data write on SIMD route: one load pulse, SYNC+2 cycles after WR
        snap_load = load_cnt;
        wr_cyc = cyc;
        bus_write(1'b1, 8'h55);
        chk("load_count", load_cnt - snap_load, 1);
        chk("load_latency", load_cyc - wr_cyc, SYNC + 2);
        chk("load_noerr", err, 0);

        // Data write on non-SIMD route is ignored
        bus_write(1'b0, 8'h00);
        snap_load = load_cnt;
        bus_write(1'b1, 8'hAA);
        chk("route0_noload", load_cnt - snap_load, 0);

        // Camera frame
        snap_fd = fd_cnt;
        bus_write(1'b0, 8'h01);
        chk("cam_arm_busy", busy, 1);
        chk("cam_arm_poc", sel_poc, 0);
        vsync_pulse();
        chk("cam_stream_poc", sel_poc, 1);
        chk("cam_stream_fd", fd_cnt - snap_fd, 0);
        vsync_pulse();
        chk("cam_done_poc", sel_poc, 0);
        chk("cam_done_fd", fd_cnt - snap_fd, 1);
        chk("cam_done_busy", busy, 0);
        chk("cam_done_err", err, 0);

        // Write during camera arm is rejected; route-0 command aborts
        bus_write(1'b0, 8'h01);
        bus_write(1'b1, 8'h33);
        chk("cam_wr_err", err, 1);
        chk("cam_wr_busy", busy, 1);
        bus_write(1'b0, 8'h00);
        chk("cam_abort_busy", busy, 0);
        chk("cam_abort_err", err, 1);
        bus_write(1'b0, 8'h80);
        chk("errclr1", err, 0);

        // SIMD read with valid result
        bus_write(1'b0, 8'h20);
        simd_valid = 1'b1;
        snap_send = send_cnt;
        snap_dir = dir_cnt;
        do_read(1'b1);
        chk("rd_send", send_cnt - snap_send, 1);
        chk("rd_dir_cycles", dir_cnt - snap_dir, 4);
        chk("rd_err", err, 0);
        chk("rd_end_dir", direction, 0);
        chk("rd_end_sod", sel_sod, 0);
        chk("rd_end_busy", busy, 0);

        // SIMD read without result: error, read still completes
        simd_valid = 1'b0;
        snap_send = send_cnt;
        snap_dir = dir_cnt;
        do_read(1'b1);
        chk("rdnv_send", send_cnt - snap_send, 0);
        chk("rdnv_err", err, 1);
        chk("rdnv_dir_cycles", dir_cnt - snap_dir, 4);
        chk("rdnv_busy", busy, 0);

        // Write/read collision: write wins, bus never driven
        bus_write(1'b0, 8'h80);
        chk("errclr2", err, 0);
        snap_dir = dir_cnt;
        a0 = 1'b0;
        pico_data_in = 8'h0A;
        cs = 1'b0;
        WR = 1'b1;
        RD = 1'b1;
        tick(6);
        WR = 1'b0;
        RD = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(6);
        chk("coll_mode", simd_mode, 2'b10);
        chk("coll_dir", dir_cnt - snap_dir, 0);
        chk("coll_err", err, 1);
        chk("coll_busy", busy, 0);
        bus_write(1'b0, 8'h80);
        chk("coll_errclr", err, 0);
        chk("coll_mode80", simd_mode, 0);

        // Async reset during camera stream
        bus_write(1'b0, 8'h01);
        vsync_pulse();
        chk("pre_rst_poc", sel_poc, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_cam_poc", sel_poc, 0);
        chk("arst_cam_busy", busy, 0);
        tick(2);
        rst = 1'b1;
        tick(4);

        // Async reset during a read
        cs = 1'b0;
        RD = 1'b1;
        tick(6);
        chk("pre_rst_dir", direction, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_dir", direction, 0);
        chk("arst_rd_busy", busy, 0);
        RD = 1'b0;
        cs = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(8);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dir", direction, 0);
        chk("post_rst_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pico_bus_ctrl.md
PICO_BUS_CTRL -- requirements
Module: pico_bus_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for cs/WR/RD/a0/cam_vsync (legal 2..3).
REQ-002 SHALL have: clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: cs, WR, RD, a0  input  1 each  raw Pico bus strobes; cs active-low, WR/RD active-high, a0=0 command / a0=1 data.
REQ-005 SHALL have: pico_data_in  input  8  Pico bus byte (sampled, not driven).
REQ-006 SHALL have: cam_vsync  input  1  raw camera frame sync.
REQ-007 SHALL have: simd_valid  input  1  SIMD result ready.
REQ-008 SHALL have: sel_poc, sel_sod, direction  output  1 each  mux selects and Pico bus output enable.
REQ-009 SHALL have: simd_load, simd_send  output  1 each  single-cycle SIMD strobes.
REQ-010 SHALL have: simd_mode  output  2, simd_dtype  output  1  SIMD configuration from command register.
REQ-011 SHALL have: busy, frame_done, err  output  1 each  status; frame_done one-cycle pulse, err sticky.

Function
REQ-012 SHALL pass cs, WR, RD, a0, cam_vsync through SYNC_STAGES flops; edges detected on synchronized values only.
REQ-013 SHALL recognise a write event on synchronized WR rising edge while synchronized cs=0; a read event likewise on RD.
REQ-014 SHALL, on simultaneous write and read events, service the write and drop the read, setting err.
REQ-015 SHALL, on write with a0=0, load pico_data_in into cmd[7:0] the next cycle: cmd[1:0] route (00 pico->LCD, 01 camera frame, 10 SIMD), cmd[3:2] simd_mode, cmd[4] simd_dtype, cmd[5] read source (1=SIMD).
REQ-016 SHALL, on write with a0=1 and route=10, pulse simd_load exactly one cycle, one cycle after the event; with route!=10 the data write is ignored.
REQ-017 SHALL implement states IDLE, CAM_ARM, CAM_STREAM, READ.
REQ-018 SHALL go IDLE->CAM_ARM on command write with route=01; CAM_ARM->CAM_STREAM on synchronized cam_vsync rising edge; CAM_STREAM->IDLE on the next such edge, pulsing frame_done that cycle.
REQ-019 SHALL drive sel_poc=1 only in CAM_STREAM; 0 elsewhere.
REQ-020 SHALL ignore all Pico writes and reads in CAM_ARM/CAM_STREAM, setting err; command write route=00 is the only exception and aborts to IDLE.
REQ-021 SHALL go IDLE->READ on read event; direction=1 from the cycle after entry until synchronized RD=0 or synchronized cs=1, then return to IDLE with direction=0 that same cycle.
REQ-022 SHALL hold sel_sod=cmd[5] throughout READ and 0 otherwise.
REQ-023 SHALL pulse simd_send one cycle on READ entry when cmd[5]=1 and simd_valid=1; if simd_valid=0 SHALL set err and still complete the read.
REQ-024 SHALL never assert direction while synchronized WR=1.
REQ-025 SHALL drive simd_mode=cmd[3:2], simd_dtype=cmd[4] continuously; busy=1 in any state but IDLE.
REQ-026 SHALL clear err only by command write with cmd[7]=1 (other fields still loaded).

Reset
REQ-027 SHALL, while rst=0, force state IDLE, cmd=0, synchronizers=0, all outputs 0, immediately and independent of clk.
REQ-028 SHALL, on reset mid-read or mid-frame, release the Pico bus (direction=0) asynchronously; no pending strobe survives.

Structure
REQ-029 SHALL place state encoding, route codes (ROUTE_PICO/ROUTE_CAM/ROUTE_SIMD) and cmd bit positions in shared package pico_bus_pkg.
REQ-030 SHALL instantiate sub-module sync_edge (parameterized depth, outputs level/rise/fall) once per synchronized input.

Verification
REQ-031 SHALL check: write a0=0 data 8'h2E -> cmd=8'h2E, simd_mode=2'b11, simd_dtype=0, route SIMD, no strobe.
REQ-032 SHALL check: route=10, write a0=1 data 8'h55 -> exactly one simd_load pulse, SYNC_STAGES+2 cycles after WR rise.
REQ-033 SHALL check: cmd=8'h01, two cam_vsync pulses -> sel_poc=1 only between them, one frame_done, busy falls after.
REQ-034 SHALL check: cmd=8'h20, simd_valid=1, RD pulse -> simd_send once, sel_sod=1, direction high only while RD synced high; repeat with simd_valid=0 -> err=1.
REQ-035 SHALL check: WR and RD rise same cycle -> write serviced, direction stays 0, err=1; then cmd=8'h80 -> err=0.
REQ-036 SHALL check: rst low during CAM_STREAM and READ -> sel_poc, direction, busy drop to 0 before next clk edge.
